// File: rtl/div32x16_signed.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, radix-2 restoring on magnitudes.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase and completes in one cycle.
module div32x16_signed #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           div_zero,
  output logic           ovf
);

  // Handshake: start is sampled only in IDLE; busy covers CALC; done pulses one cycle
  // with q/r/div_zero/ovf, which then hold until the next done.
  localparam int CW = $clog2(2*N);
  localparam logic [2*N-1:0] QPOS    = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] QNEG    = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   SAT_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] dvd;
  logic [N-1:0]   rem;
  logic [N-1:0]   bmag;
  logic           sa;
  logic           sb;
  logic           bz;

  logic [2*N-1:0] amag_in;
  logic [N-1:0]   bmag_in;
  logic [N:0]     rem_sh;
  logic           ge;
  logic [N-1:0]   rem_nx;
  logic           q_neg;
  logic           over;
  logic [N-1:0]   q_norm;
  logic [N-1:0]   r_norm;

  always_comb begin
    amag_in = A[2*N-1] ? -A : A;
    bmag_in = B[N-1] ? -B : B;
    rem_sh  = {rem, dvd[2*N-1]};
    // The partial remainder stays below |B|, so the subtraction result always fits in N bits.
    ge      = rem_sh[N] | (rem_sh[N-1:0] >= bmag);
    rem_nx  = ge ? (rem_sh[N-1:0] - bmag) : rem_sh[N-1:0];
    q_neg   = sa ^ sb;
    over    = q_neg ? (dvd > QNEG) : (dvd > QPOS);
    q_norm  = q_neg ? -dvd[N-1:0] : dvd[N-1:0];
    r_norm  = sa ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      rem      <= '0;
      bmag     <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      bz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= A[2*N-1];
            sb   <= B[N-1];
            bz   <= (B == '0);
            dvd  <= amag_in;
            bmag <= bmag_in;
            rem  <= '0;
            cnt  <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (B == '0) begin
              state <= FIX;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= {dvd[2*N-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(2*N-1)) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (bz) begin
            q        <= sa ? SAT_NEG : SAT_POS;
            r        <= '0;
            div_zero <= 1'b1;
            ovf      <= 1'b0;
          end else if (over) begin
            q        <= q_neg ? SAT_NEG : SAT_POS;
            r        <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b1;
          end else begin
            q        <= q_norm;
            r        <= r_norm;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32x16_signed.sv
// Bench for div32x16_signed: queue-based scoreboard fed at stimulus time, drained on each done pulse.
module tb_div32x16_signed;
  localparam int N = 16;
  localparam int W = 2*N + 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           div_zero;
  logic           ovf;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int errors = 0;
  int checks = 0;

  div32x16_signed #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero), .ovf(ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Verilog integer division truncates toward zero, remainder follows the dividend.
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [15:0] b);
    longint sa, sb, qt, rt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {(a[31] ? 16'h8000 : 16'h7fff), 16'h0000, 1'b1, 1'b0};
    qt = sa / sb;
    rt = sa % sb;
    if (qt > 32767 || qt < -32768) return {(qt > 0 ? 16'h7fff : 16'h8000), 16'h0000, 1'b0, 1'b1};
    return {qt[15:0], rt[15:0], 2'b00};
  endfunction

  // scoreboard
  always @(posedge clk) begin
    #1;
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got q=%h r=%h dz=%b ovf=%b, required no done", q, r, div_zero, ovf);
      end else begin
        last_exp = exp_q.pop_front();
        if ({q, r, div_zero, ovf} !== last_exp) begin
          errors++;
          $display("FAIL sb_result: got q=%h r=%h dz=%b ovf=%b, required q=%h r=%h dz=%b ovf=%b",
                   q, r, div_zero, ovf, last_exp[33:18], last_exp[17:2], last_exp[1], last_exp[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_op(input logic [31:0] a, input logic [15:0] b);
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 100);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, q, r, div_zero, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, required all 0",
               busy, done, q, r, div_zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_signs;
    logic [31:0] ta[7] = '{32'h0100_0000, -32'sd7, 32'd7, 32'd100, 32'd0, 32'hFFFF_8000, 32'd32767};
    logic [15:0] tb[7] = '{16'hF000, 16'd2, -16'sd2, 16'd7, 16'd5, 16'd1, 16'h8000};
    int c;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_op(ta[i], tb[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL signs_busy[%0d]: got %b, required 1", i, busy);
      end
      wait_done(c);
      checks++;
      if (c != 33) begin
        errors++;
        $display("FAIL signs_latency[%0d]: got %0d cycles, required 33", i, c);
      end
    end
  endtask

  task automatic test_ovf;
    logic [31:0] ta[5] = '{32'h8000_0000, 32'h4000_0000, 32'd32768, 32'd32768, 32'hFFFF_7FFF};
    logic [15:0] tb[5] = '{16'hFFFF, 16'd1, 16'd1, 16'hFFFF, 16'd1};
    int c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_op(ta[i], tb[i]);
      wait_done(c);
      checks++;
      if (c != 33) begin
        errors++;
        $display("FAIL ovf_latency[%0d]: got %0d cycles, required 33", i, c);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] ta[3] = '{32'd1234, -32'sd5, 32'd0};
    int c;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(ta[i], 16'd0);
      checks++;
      if (busy !== (ZLAT != 1)) begin
        errors++;
        $display("FAIL dz_busy[%0d]: got %b, required %b", i, busy, (ZLAT != 1));
      end
      wait_done(c);
      checks++;
      if (c != ZLAT) begin
        errors++;
        $display("FAIL dz_latency[%0d]: got %0d cycles, required %0d", i, c, ZLAT);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [15:0] b;
    longint k;
    int c;
    for (int i = 0; i < 16; i++) begin
      b = 16'($urandom);
      if (b == 16'd0) b = 16'd3;
      if (i % 2 == 0) begin
        a = $urandom;
      end else begin
        k = longint'($urandom_range(0, 65535)) - 32768;
        a = 32'(longint'($signed(b)) * k + longint'($urandom_range(0, 5)));
      end
      @(negedge clk);
      drive_op(a, b);
      wait_done(c);
      checks++;
      if (c != 33) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d cycles, required 33", i, c);
      end
    end
  endtask

  task automatic test_start_ignored;
    int c;
    int extra;
    @(negedge clk);
    drive_op(32'd5000, 16'd9);
    repeat (8) @(posedge clk);
    @(negedge clk);
    A = 32'd77;
    B = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Accept edge plus 9 edges already consumed, so 24 remain until done.
    wait_done(c);
    checks++;
    if (c != 24) begin
      errors++;
      $display("FAIL ignored_latency: got %0d cycles, required 24", c);
    end
    extra = 0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_extra_done: got %0d pulses, required 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    @(negedge clk);
    drive_op(-32'sd1000, 16'd33);
    wait_done(c);
    checks++;
    if (c != 33) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d cycles, required 33", c);
    end
    drive_op(32'd65535, -16'sd300);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b, required 1", busy);
    end
    wait_done(c);
    checks++;
    if (c != 33) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d cycles, required 33", c);
    end
  endtask

  task automatic test_hold;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({q, r, div_zero, ovf} !== last_exp || done !== 1'b0) begin
      errors++;
      $display("FAIL hold: got q=%h r=%h dz=%b ovf=%b done=%b, required q=%h r=%h dz=%b ovf=%b done=0",
               q, r, div_zero, ovf, done, last_exp[33:18], last_exp[17:2], last_exp[1], last_exp[0]);
    end
  endtask

  task automatic test_reset_abort;
    int c;
    int seen;
    @(negedge clk);
    drive_op(32'd7777, 16'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, q, r, div_zero, ovf} !== '0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, required all 0",
               busy, done, q, r, div_zero, ovf);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", seen);
    end
    @(negedge clk);
    drive_op(32'd100, 16'd7);
    wait_done(c);
    checks++;
    if (c != 33 || q !== 16'd14 || r !== 16'd2) begin
      errors++;
      $display("FAIL abort_next_op: got %0d cycles q=%0d r=%0d, required 33 cycles q=14 r=2", c, q, r);
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_ovf();
    test_div_zero();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
